// File: rtl/bcd_serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
//   Bundle of the request/result bus and the shared digit-adder bus used by
//   bcd_serial_add_ctrl.
//
//   Request/result side:
//     start     request pulse (sampled only while the controller is idle)
//     a, b      packed-BCD operands, digit 0 in bits [3:0]
//     op        1 = subtract A-B (present only when BCD_SUB_EN is defined)
//     busy      operation in progress
//     done      one-cycle completion pulse
//     sum       result digits, held until the next accepted start
//     cout      decimal carry out of the top digit (no-borrow flag when
//               subtracting)
//     err       some latched operand digit was above 9
//   Shared adder side:
//     da, db    digit pair presented to the adder
//     dcin      carry into the adder
//     dsum      digit sum returned by the adder (combinational)
//     dcout     decimal carry returned by the adder
//
//   Modports: master = requester, slave = controller, adder = digit cell.
//   Optional feature macro: BCD_SUB_EN.
// -----------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
`ifdef BCD_SUB_EN
   logic                  op;
`endif
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  err;
   logic [3:0]            da;
   logic [3:0]            db;
   logic                  dcin;
   logic [3:0]            dsum;
   logic                  dcout;

`ifdef BCD_SUB_EN
   modport master (output start, a, b, op, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, op, output busy, done, sum, cout, err,
                   output da, db, dcin, input dsum, dcout);
`else
   modport master (output start, a, b, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, output busy, done, sum, cout, err,
                   output da, db, dcin, input dsum, dcout);
`endif
   modport adder  (input da, db, dcin, output dsum, dcout);
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_serial_add_ctrl
//   Multi-digit BCD add built around one external single-digit BCD adder.
//   Operands are latched on start; one digit pair per clock is sent to the
//   shared adder, least-significant digit first, with the decimal carry
//   rippled through an internal register. Completion is a one-cycle done
//   pulse; sum/cout/err are held until the next accepted start.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous reset, active-low
//     bus    bcd_serial_add_ctrl_if.slave (request/result + shared adder)
//
//   Parameters:
//     DIGITS  number of BCD digits per operand (>= 1)
//     IDXW    digit index width, 2**IDXW >= DIGITS
//
//   Optional feature macro: BCD_SUB_EN -- adds bus.op; op=1 computes A-B by
//   ten's complement (nine's complement of B digits, initial carry 1).
// -----------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4,
   parameter int IDXW   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bcd_serial_add_ctrl_if.slave   bus
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [W-1:0]      a_r;
   logic [W-1:0]      b_r;
   logic [W-1:0]      sum_r;
   logic [IDXW-1:0]   idx;
   logic              carry;
   logic              cout_r;
   logic              err_r;
   logic              op_r;

   logic              last_digit;
   logic              in_run;
   logic [3:0]        a_dig;
   logic [3:0]        b_dig;
   logic [3:0]        b_eff;
   logic              op_in;
   logic              start_err;

   // True if any digit of a packed-BCD word is not a decimal digit.
   function automatic logic has_invalid(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

`ifdef BCD_SUB_EN
   assign op_in = bus.op;
`else
   assign op_in = 1'b0;
`endif

   assign start_err  = has_invalid(bus.a) | has_invalid(bus.b);
   assign last_digit = (idx == IDXW'(DIGITS - 1));
   assign in_run     = (state == RUN);
   assign a_dig      = a_r[4*int'(idx) +: 4];
   assign b_dig      = b_r[4*int'(idx) +: 4];

   // Nine's complement of the B digit when subtracting; an invalid digit has
   // no meaningful complement, so 0 is sent and err reports the operation.
   always_comb begin
      b_eff = b_dig;
      if (op_r) begin
         b_eff = (b_dig > 4'd9) ? 4'd0 : 4'd9 - b_dig;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every signal assigned in a combinational block gets a default
   // before the case statement, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_digit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   // NOTE: all registered state uses non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of order.
   // NOTE: the operand latches are a handful of flops, not a memory array, so
   // they are reset with everything else and never leak a stale value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         err_r  <= 1'b0;
         op_r   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r   <= bus.a;
                  b_r   <= bus.b;
                  op_r  <= op_in;
                  idx   <= '0;
                  // Subtraction is A + (nines' complement of B) + 1.
                  carry <= op_in;
                  err_r <= start_err;
               end
            end
            RUN: begin
               sum_r[4*int'(idx) +: 4] <= bus.dsum;
               carry                   <= bus.dcout;
               if (last_digit) begin
                  cout_r <= bus.dcout;
                  idx    <= '0;
               end else begin
                  idx    <= idx + IDXW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.err  = err_r;
   assign bus.da   = in_run ? a_dig : 4'd0;
   assign bus.db   = in_run ? b_eff : 4'd0;
   assign bus.dcin = in_run & carry;

endmodule
